// File: rtl/mem_interconnect_n_pkg.sv
// Shared types and widths for the core-to-memory interconnect.
package mem_interconnect_n_pkg;
  localparam int NUM_OF_CORES = 4;
  localparam int CORE_ID_W    = 8;
  localparam int LEN_W        = 4;
  localparam int ADDR_W       = 32;
  localparam int DATA_W       = 32;

  typedef struct packed {
    logic                 vld;
    logic [CORE_ID_W-1:0] core_id;
    logic [LEN_W-1:0]     access_length;
    logic [ADDR_W-1:0]    addr;
    logic [DATA_W-1:0]    data;
  } request_t;
endpackage

// File: rtl/wrr_credit_arbiter.sv
// Credit-based weighted round-robin arbiter: the winner keeps the grant for
// max(weight,1) consecutive wins while it stays eligible.
module wrr_credit_arbiter #(
  parameter int N  = 4,
  parameter int W  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N-1:0]        eligible,
  input  logic [N-1:0][W-1:0] weight,
  input  logic                advance,
  output logic [N-1:0]        grant,
  output logic [IW-1:0]       gnt_idx,
  output logic                gnt_vld
);
  logic [IW-1:0] ptr, owner;
  logic [W-1:0]  credit;   // wins left for owner after the current one
  logic          cont;
  int            cand;

  assign cont = (credit != '0) && eligible[owner];

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = 0;
    if (advance) begin
      if (cont) begin
        gnt_vld = 1'b1;
        gnt_idx = owner;
      end else begin
        for (int k = 0; k < N; k++) begin
          cand = int'(ptr) + k;
          if (cand >= N) cand = cand - N;
          if (!gnt_vld && eligible[cand]) begin
            gnt_vld = 1'b1;
            gnt_idx = IW'(cand);
          end
        end
      end
    end
  end

  always_comb begin
    grant = '0;
    if (gnt_vld) grant[gnt_idx] = 1'b1;
  end

  // ptr is parked at owner+1 on every new grant, so exhausting credit or
  // losing eligibility both resume the search just after the owner.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr    <= '0;
      owner  <= '0;
      credit <= '0;
    end else if (advance) begin
      if (cont) begin
        credit <= credit - W'(1);
      end else if (gnt_vld) begin
        owner  <= gnt_idx;
        ptr    <= (gnt_idx == IW'(N-1)) ? '0 : gnt_idx + IW'(1);
        credit <= (weight[gnt_idx] == '0) ? '0 : weight[gnt_idx] - W'(1);
      end else begin
        credit <= '0;
      end
    end
  end
endmodule

// File: rtl/mem_interconnect_n.sv
// NUM_CORES-to-one memory interconnect: WRR arbitration, registered mem_req,
// per-core outstanding limit and registered response demux.
module mem_interconnect_n
  import mem_interconnect_n_pkg::*;
#(
  parameter int NUM_CORES       = NUM_OF_CORES,
  parameter int MAX_OUTSTANDING = 8,
  parameter int ID_W            = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1,
  localparam int OW             = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  request_t [NUM_CORES-1:0]        core_req,
  output logic [NUM_CORES-1:0]            core_grant,
  output request_t [NUM_CORES-1:0]        core_rsp,
  output request_t                        mem_req,
  input  logic                            mem_ready,
  input  request_t                        mem_rsp,
  output logic [NUM_CORES-1:0][OW-1:0]    outstanding,
  output logic                            rsp_err
);
  localparam logic [OW-1:0] MAX_CNT = OW'(MAX_OUTSTANDING);

  logic [NUM_CORES-1:0]            eligible, rsp_hit, dec_ok, zero_err;
  logic [NUM_CORES-1:0][LEN_W-1:0] weight;
  logic [ID_W-1:0]                 gnt_idx;
  logic                            gnt_vld, advance, rsp_in_range;

  // Grants are suppressed while in reset so core_grant reads 0 too.
  assign advance      = (!mem_req.vld || mem_ready) && !reset;
  assign rsp_in_range = mem_rsp.core_id < CORE_ID_W'(NUM_CORES);

  always_comb begin
    eligible = '0;
    weight   = '0;
    rsp_hit  = '0;
    dec_ok   = '0;
    zero_err = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      eligible[i] = core_req[i].vld && (outstanding[i] < MAX_CNT);
      weight[i]   = core_req[i].access_length;
      rsp_hit[i]  = mem_rsp.vld && (mem_rsp.core_id == CORE_ID_W'(i));
      dec_ok[i]   = rsp_hit[i] && (outstanding[i] != '0);
      zero_err[i] = rsp_hit[i] && (outstanding[i] == '0);
    end
  end

  wrr_credit_arbiter #(.N(NUM_CORES), .W(LEN_W), .IW(ID_W)) u_arb (
    .clk      (clk),
    .reset    (reset),
    .eligible (eligible),
    .weight   (weight),
    .advance  (advance),
    .grant    (core_grant),
    .gnt_idx  (gnt_idx),
    .gnt_vld  (gnt_vld)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_req <= '0;
    end else if (gnt_vld) begin
      mem_req         <= core_req[gnt_idx];
      mem_req.core_id <= CORE_ID_W'(gnt_idx);
    end else if (mem_ready) begin
      mem_req <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      outstanding <= '0;
      core_rsp    <= '0;
      rsp_err     <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CORES; i++) begin
        core_rsp[i] <= rsp_hit[i] ? mem_rsp : '0;
        if (core_grant[i] && !dec_ok[i])
          outstanding[i] <= outstanding[i] + OW'(1);
        else if (!core_grant[i] && dec_ok[i])
          outstanding[i] <= outstanding[i] - OW'(1);
      end
      if ((mem_rsp.vld && !rsp_in_range) || (|zero_err)) rsp_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_mem_interconnect_n.sv
// Directed bench for mem_interconnect_n: dut_a uses default limits, dut_b
// has MAX_OUTSTANDING=2 for the per-core limit scenario.
module tb_mem_interconnect_n;
  import mem_interconnect_n_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  request_t [3:0] a_req, a_rsp, b_req, b_rsp;
  request_t       a_mreq, a_mrsp, b_mreq, b_mrsp;
  logic [3:0]     a_grant, b_grant;
  logic           a_ready, b_ready, a_err, b_err;
  logic [3:0][3:0] a_out;
  logic [3:0][1:0] b_out;

  mem_interconnect_n #(.NUM_CORES(4), .MAX_OUTSTANDING(8)) dut_a (
    .clk(clk), .reset(reset), .core_req(a_req), .core_grant(a_grant),
    .core_rsp(a_rsp), .mem_req(a_mreq), .mem_ready(a_ready),
    .mem_rsp(a_mrsp), .outstanding(a_out), .rsp_err(a_err));

  mem_interconnect_n #(.NUM_CORES(4), .MAX_OUTSTANDING(2)) dut_b (
    .clk(clk), .reset(reset), .core_req(b_req), .core_grant(b_grant),
    .core_rsp(b_rsp), .mem_req(b_mreq), .mem_ready(b_ready),
    .mem_rsp(b_mrsp), .outstanding(b_out), .rsp_err(b_err));

  function automatic request_t mk(input int len, input logic [31:0] addr);
    request_t r;
    r = '0;
    r.vld = 1'b1;
    r.core_id = 8'hEE;
    r.access_length = 4'(len);
    r.addr = addr;
    return r;
  endfunction

  function automatic request_t mkrsp(input int id, input logic [31:0] d);
    request_t r;
    r = '0;
    r.vld = 1'b1;
    r.core_id = 8'(id);
    r.data = d;
    return r;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    a_req = '0; b_req = '0; a_mrsp = '0; b_mrsp = '0;
    a_ready = 1'b1; b_ready = 1'b1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    cyc();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_inputs();
    a_req[0] = mk(1, 32'h10);
    cyc();
    n_chk++; if (a_grant !== 4'b0) begin n_fail++; $display("FAIL reset_grant: got %b want 0000", a_grant); end
    n_chk++; if (a_mreq !== '0) begin n_fail++; $display("FAIL reset_mem_req: got %h want 0", a_mreq); end
    n_chk++; if (a_out !== '0) begin n_fail++; $display("FAIL reset_outstanding: got %h want 0", a_out); end
    n_chk++; if (a_rsp !== '0 || a_err !== 1'b0) begin n_fail++; $display("FAIL reset_rsp: got rsp %h err %b want 0/0", a_rsp, a_err); end
    a_req = '0;
    reset = 1'b0;
  endtask

  task automatic test_single_core();
    logic [3:0]  exp_g [4];
    logic [7:0]  exp_id [4];
    logic [31:0] exp_a [4];
    exp_g  = '{4'b0001, 4'b0001, 4'b0001, 4'b0010};
    exp_id = '{8'd0, 8'd0, 8'd0, 8'd1};
    exp_a  = '{32'h100, 32'h100, 32'h100, 32'h200};
    do_reset();
    a_req[0] = mk(3, 32'h100);
    a_req[1] = mk(1, 32'h200);
    for (int c = 0; c < 4; c++) begin
      #1;
      n_chk++; if (a_grant !== exp_g[c]) begin n_fail++; $display("FAIL single_grant c%0d: got %b want %b", c, a_grant, exp_g[c]); end
      cyc();
      n_chk++;
      if (a_mreq.vld !== 1'b1 || a_mreq.core_id !== exp_id[c] || a_mreq.addr !== exp_a[c]) begin
        n_fail++; $display("FAIL single_mem_req c%0d: got vld %b id %0d addr %h want 1 %0d %h",
                           c, a_mreq.vld, a_mreq.core_id, a_mreq.addr, exp_id[c], exp_a[c]);
      end
      if (c == 2) a_req[0] = '0;
      if (c == 3) a_req[1] = '0;
    end
    n_chk++; if (a_out[0] !== 4'd3 || a_out[1] !== 4'd1) begin n_fail++; $display("FAIL single_outstanding: got %0d/%0d want 3/1", a_out[0], a_out[1]); end
    cyc();
    n_chk++; if (a_mreq.vld !== 1'b0) begin n_fail++; $display("FAIL single_mem_req_clear: got vld %b want 0", a_mreq.vld); end
  endtask

  task automatic test_backpressure();
    do_reset();
    a_req[2] = mk(1, 32'h300);
    #1;
    n_chk++; if (a_grant !== 4'b0100) begin n_fail++; $display("FAIL bp_first_grant: got %b want 0100", a_grant); end
    cyc();
    a_req[2] = '0;
    a_ready = 1'b0;
    a_req[3] = mk(1, 32'h400);
    for (int c = 0; c < 5; c++) begin
      #1;
      n_chk++; if (a_grant !== 4'b0) begin n_fail++; $display("FAIL bp_no_grant c%0d: got %b want 0000", c, a_grant); end
      cyc();
      n_chk++;
      if (a_mreq.vld !== 1'b1 || a_mreq.core_id !== 8'd2 || a_mreq.addr !== 32'h300) begin
        n_fail++; $display("FAIL bp_hold c%0d: got vld %b id %0d addr %h want 1 2 300", c, a_mreq.vld, a_mreq.core_id, a_mreq.addr);
      end
    end
    a_ready = 1'b1;
    #1;
    n_chk++; if (a_grant !== 4'b1000) begin n_fail++; $display("FAIL bp_release_grant: got %b want 1000", a_grant); end
    cyc();
    a_req[3] = '0;
    n_chk++; if (a_mreq.core_id !== 8'd3 || a_mreq.addr !== 32'h400) begin n_fail++; $display("FAIL bp_release_req: got id %0d addr %h want 3 400", a_mreq.core_id, a_mreq.addr); end
    n_chk++; if (a_out[2] !== 4'd1 || a_out[3] !== 4'd1) begin n_fail++; $display("FAIL bp_outstanding: got %0d/%0d want 1/1", a_out[2], a_out[3]); end
  endtask

  task automatic test_outstanding_limit();
    do_reset();
    b_req[2] = mk(1, 32'h500);
    for (int c = 0; c < 2; c++) begin
      #1;
      n_chk++; if (b_grant !== 4'b0100) begin n_fail++; $display("FAIL lim_grant c%0d: got %b want 0100", c, b_grant); end
      cyc();
      n_chk++; if (b_out[2] !== 2'(c + 1)) begin n_fail++; $display("FAIL lim_count c%0d: got %0d want %0d", c, b_out[2], c + 1); end
    end
    #1;
    n_chk++; if (b_grant !== 4'b0) begin n_fail++; $display("FAIL lim_blocked: got %b want 0000", b_grant); end
    b_mrsp = mkrsp(2, 32'h55);
    cyc();
    b_mrsp = '0;
    n_chk++; if (b_out[2] !== 2'd1) begin n_fail++; $display("FAIL lim_after_rsp: got %0d want 1", b_out[2]); end
    n_chk++; if (b_rsp[2].vld !== 1'b1 || b_rsp[2].data !== 32'h55) begin n_fail++; $display("FAIL lim_rsp_route: got vld %b data %h want 1 55", b_rsp[2].vld, b_rsp[2].data); end
    #1;
    n_chk++; if (b_grant !== 4'b0100) begin n_fail++; $display("FAIL lim_regrant: got %b want 0100", b_grant); end
    cyc();
    b_req = '0;
    n_chk++; if (b_out[2] !== 2'd2 || b_err !== 1'b0) begin n_fail++; $display("FAIL lim_final: got cnt %0d err %b want 2 0", b_out[2], b_err); end
  endtask

  task automatic test_routing();
    request_t exp_r;
    do_reset();
    a_req[3] = mk(1, 32'h800);
    cyc();
    a_req[3] = '0;
    n_chk++; if (a_out[3] !== 4'd1) begin n_fail++; $display("FAIL route_pre_count: got %0d want 1", a_out[3]); end
    exp_r = mkrsp(3, 32'hCAFE);
    a_mrsp = exp_r;
    cyc();
    a_mrsp = '0;
    n_chk++; if (a_rsp[3] !== exp_r) begin n_fail++; $display("FAIL route_core3: got %h want %h", a_rsp[3], exp_r); end
    n_chk++; if (a_rsp[0] !== '0 || a_rsp[1] !== '0 || a_rsp[2] !== '0) begin n_fail++; $display("FAIL route_others: got %h %h %h want 0", a_rsp[0], a_rsp[1], a_rsp[2]); end
    n_chk++; if (a_out[3] !== 4'd0 || a_err !== 1'b0) begin n_fail++; $display("FAIL route_count: got %0d err %b want 0 0", a_out[3], a_err); end
    cyc();
    n_chk++; if (a_rsp !== '0) begin n_fail++; $display("FAIL route_pulse: got %h want 0", a_rsp); end
    a_mrsp = mkrsp(4, 32'hBAD);
    cyc();
    a_mrsp = '0;
    n_chk++; if (a_err !== 1'b1 || a_rsp !== '0) begin n_fail++; $display("FAIL route_oor: got err %b rsp %h want 1 0", a_err, a_rsp); end
    cyc(); cyc();
    n_chk++; if (a_err !== 1'b1) begin n_fail++; $display("FAIL route_sticky: got %b want 1", a_err); end
  endtask

  task automatic test_fairness();
    logic [3:0] exp;
    do_reset();
    for (int i = 0; i < 4; i++) a_req[i] = mk(1, 32'h900 + 32'(i));
    for (int c = 0; c < 8; c++) begin
      exp = 4'b0001 << (c % 4);
      #1;
      n_chk++; if (a_grant !== exp) begin n_fail++; $display("FAIL fair_grant c%0d: got %b want %b", c, a_grant, exp); end
      cyc();
    end
    a_req = '0;
    n_chk++; if (a_out !== {4'd2, 4'd2, 4'd2, 4'd2}) begin n_fail++; $display("FAIL fair_outstanding: got %h want 2222", a_out); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    a_req[1] = mk(4, 32'h600);
    #1;
    n_chk++; if (a_grant !== 4'b0010) begin n_fail++; $display("FAIL mid_first: got %b want 0010", a_grant); end
    cyc();
    #1;
    n_chk++; if (a_grant !== 4'b0010) begin n_fail++; $display("FAIL mid_burst: got %b want 0010", a_grant); end
    reset = 1'b1;
    a_req[0] = mk(1, 32'h700);
    cyc();
    n_chk++;
    if (a_mreq !== '0 || a_grant !== 4'b0 || a_out !== '0 || a_rsp !== '0 || a_err !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset_outputs: got mreq %h grant %b out %h err %b want all 0", a_mreq, a_grant, a_out, a_err);
    end
    reset = 1'b0;
    #1;
    n_chk++; if (a_grant !== 4'b0001) begin n_fail++; $display("FAIL mid_core0_first: got %b want 0001", a_grant); end
    cyc();
    a_req = '0;
    a_mrsp = mkrsp(1, 32'h1);
    cyc();
    a_mrsp = '0;
    n_chk++; if (a_err !== 1'b1 || a_out[1] !== 4'd0) begin n_fail++; $display("FAIL mid_stale_rsp: got err %b cnt %0d want 1 0", a_err, a_out[1]); end
  endtask

  initial begin
    test_reset();
    test_single_core();
    test_backpressure();
    test_outstanding_limit();
    test_routing();
    test_fairness();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
